// File: rtl/parallel_to_serial_commutator.sv
// parallel_to_serial_commutator
// Output commutator for the CIC/polyphase datapath. It takes gp_nr_stages
// words in one parallel load and emits them one per enabled clock, starting
// with the lowest slice. The next frame can be loaded on the cycle that shows
// the last word, so frames can run back to back with no gap.
//
// Optional feature: define PISO_OVERRUN_FLAG_EN to build a sticky overrun
// flag. The flag records loads requested while the block was not ready. When
// the macro is undefined, o_overrun is tied low and rejected loads are dropped
// silently.
module parallel_to_serial_commutator #(
   parameter int gp_data_width = 8,
   parameter int gp_nr_stages  = 4
) (
   input  logic                                  i_clk,
   input  logic                                  i_rst_an,
   input  logic                                  i_ena,
   input  logic                                  i_load,
   input  logic [gp_nr_stages*gp_data_width-1:0] i_data,
   output logic [gp_data_width-1:0]              o_data,
   output logic                                  o_valid,
   output logic                                  o_last,
   output logic                                  o_ready,
   output logic                                  o_overrun
);

   localparam int CW = $clog2(gp_nr_stages);
   localparam int BW = (gp_nr_stages-1)*gp_data_width;
   localparam logic [CW-1:0] LAST_IDX = CW'(gp_nr_stages-1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   r_cnt;
   // Slices 1..N-1 waiting to be sent. The next word is always in the low slice.
   logic [BW-1:0]   bank;
   logic            last, ready, accept;

   // State register
   always_ff @(posedge i_clk or negedge i_rst_an) begin
      if (!i_rst_an)  state <= IDLE;
      else if (i_ena) state <= state_nxt;
   end

   // Next-state, handshake and frame-end decode
   always_comb begin
      state_nxt = state;
      last      = o_valid & (r_cnt == LAST_IDX);
      ready     = (state == IDLE) | last;
      accept    = i_load & ready;
      case (state)
         IDLE:    if (accept) state_nxt = SHIFT;
         SHIFT:   if (accept) state_nxt = SHIFT;
                  else if (last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign o_last  = last;
   assign o_ready = ready;

   // Datapath: a load presents slice 0 and banks the rest. Each following
   // enabled edge shifts the next slice out. After the last word, o_data
   // keeps that word and o_valid drops.
   always_ff @(posedge i_clk or negedge i_rst_an) begin
      if (!i_rst_an) begin
         o_data  <= '0;
         o_valid <= 1'b0;
         r_cnt   <= '0;
         bank    <= '0;
      end else if (i_ena) begin
         if (accept) begin
            o_data  <= i_data[gp_data_width-1:0];
            bank    <= i_data[gp_nr_stages*gp_data_width-1:gp_data_width];
            o_valid <= 1'b1;
            r_cnt   <= '0;
         end else if (state == SHIFT && !last) begin
            o_data  <= bank[gp_data_width-1:0];
            bank    <= bank >> gp_data_width;
            r_cnt   <= r_cnt + 1'b1;
         end else if (state == SHIFT) begin
            o_valid <= 1'b0;
         end
      end
   end

`ifdef PISO_OVERRUN_FLAG_EN
   logic overrun;

   // Sticky overrun flag. It sets on any enabled load request while not ready
   // and is cleared only by reset.
   always_ff @(posedge i_clk or negedge i_rst_an) begin
      if (!i_rst_an)                        overrun <= 1'b0;
      else if (i_ena && i_load && !ready)   overrun <= 1'b1;
   end

   assign o_overrun = overrun;
`else
   assign o_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_parallel_to_serial_commutator.sv
// Testbench for parallel_to_serial_commutator. It instantiates three copies
// with N=4, N=2 and N=7. Directed tests use a table of vectors plus
// hand-written sequences for overrun and asynchronous reset. Random sweeps
// compare each instance against a queue-based frame model.
module tb_parallel_to_serial_commutator;

   localparam int W = 8;
`ifdef PISO_OVERRUN_FLAG_EN
   localparam bit OVR_EN = 1'b1;
`else
   localparam bit OVR_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   logic [2:0]         ena_v, load_v;
   logic [2:0][55:0]   din_v;
   logic [2:0][W-1:0]  q_v;
   logic [2:0]         val_v, last_v, rdy_v, ovr_v;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   parallel_to_serial_commutator #(.gp_data_width(W), .gp_nr_stages(4)) u_n4 (
      .i_clk(clk), .i_rst_an(rst_n), .i_ena(ena_v[0]), .i_load(load_v[0]),
      .i_data(din_v[0][31:0]), .o_data(q_v[0]), .o_valid(val_v[0]),
      .o_last(last_v[0]), .o_ready(rdy_v[0]), .o_overrun(ovr_v[0]));

   parallel_to_serial_commutator #(.gp_data_width(W), .gp_nr_stages(2)) u_n2 (
      .i_clk(clk), .i_rst_an(rst_n), .i_ena(ena_v[1]), .i_load(load_v[1]),
      .i_data(din_v[1][15:0]), .o_data(q_v[1]), .o_valid(val_v[1]),
      .o_last(last_v[1]), .o_ready(rdy_v[1]), .o_overrun(ovr_v[1]));

   parallel_to_serial_commutator #(.gp_data_width(W), .gp_nr_stages(7)) u_n7 (
      .i_clk(clk), .i_rst_an(rst_n), .i_ena(ena_v[2]), .i_load(load_v[2]),
      .i_data(din_v[2][55:0]), .o_data(q_v[2]), .o_valid(val_v[2]),
      .o_last(last_v[2]), .o_ready(rdy_v[2]), .o_overrun(ovr_v[2]));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive instance 0 for one clock and sample 1 time unit after the edge.
   task automatic step(input logic e, input logic l, input logic [31:0] d);
      ena_v[0]  = e;
      load_v[0] = l;
      din_v[0]  = 56'(d);
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        ena;
      logic        load;
      logic [31:0] data;
      logic [7:0]  e_data;
      logic        e_valid;
      logic        e_last;
      logic        e_ready;
   } vec_t;

   vec_t tbl[24];

   // Randomized sweep against a frame model. A frame is a queue of pending
   // words. The model is ready when nothing is being shown or when the shown
   // word is the last of its frame.
   task automatic run_random(input int idx, input int n, input int frames);
      logic [7:0]  cur = '0;
      logic        mv  = 1'b0;
      logic        ov  = 1'b0;
      logic [7:0]  pend[$];
      logic [63:0] rnd;
      logic [55:0] d;
      logic        e, l, rdy_m;
      int          accepted = 0;
      int          cyc = 0;
      int          drain = 0;
      string       tag;
      tag = $sformatf("rnd_n%0d", n);
      while (drain < n + 2) begin
         rnd = {$urandom, $urandom};
         d   = rnd[55:0];
         e   = ($urandom_range(0, 9) != 0);
         l   = (accepted < frames) && ($urandom_range(0, 3) != 0);
         if (accepted >= frames) drain++;
         rdy_m = !mv || (pend.size() == 0);
         ena_v[idx] = e; load_v[idx] = l; din_v[idx] = d;
         @(posedge clk);
         #1;
         if (e) begin
            if (l && rdy_m) begin
               cur = d[7:0];
               pend.delete();
               for (int k = 1; k < n; k++) pend.push_back(d[k*8 +: 8]);
               mv = 1'b1;
               accepted++;
            end else begin
               if (l) ov = 1'b1;
               if (mv && pend.size() != 0) cur = pend.pop_front();
               else if (mv) mv = 1'b0;
            end
         end
         chk({tag, "_data"},  64'(q_v[idx]),    64'(cur));
         chk({tag, "_valid"}, 64'(val_v[idx]),  64'(mv));
         chk({tag, "_last"},  64'(last_v[idx]), 64'(mv && pend.size() == 0));
         chk({tag, "_ready"}, 64'(rdy_v[idx]),  64'(!mv || pend.size() == 0));
         chk({tag, "_ovr"},   64'(ovr_v[idx]),  64'(OVR_EN & ov));
         cyc++;
         if (cyc > 20000) begin
            chk({tag, "_budget"}, 64'(accepted), 64'(frames));
            break;
         end
      end
      ena_v[idx] = 1'b0; load_v[idx] = 1'b0;
   endtask

   initial begin
      ena_v = '0; load_v = '0; din_v = '0;
      rst_n = 1'b0;

      //             ena load data          q      v  l  rdy
      tbl[0]  = '{1, 1, 32'h44332211, 8'h11, 1, 0, 0};
      tbl[1]  = '{1, 0, 32'h0,        8'h22, 1, 0, 0};
      tbl[2]  = '{1, 0, 32'h0,        8'h33, 1, 0, 0};
      tbl[3]  = '{1, 0, 32'h0,        8'h44, 1, 1, 1};
      tbl[4]  = '{1, 0, 32'h0,        8'h44, 0, 0, 1};
      tbl[5]  = '{1, 1, 32'h44332211, 8'h11, 1, 0, 0};
      tbl[6]  = '{1, 0, 32'h0,        8'h22, 1, 0, 0};
      tbl[7]  = '{1, 0, 32'h0,        8'h33, 1, 0, 0};
      tbl[8]  = '{1, 0, 32'h0,        8'h44, 1, 1, 1};
      tbl[9]  = '{1, 1, 32'h88776655, 8'h55, 1, 0, 0};
      tbl[10] = '{1, 0, 32'h0,        8'h66, 1, 0, 0};
      tbl[11] = '{1, 0, 32'h0,        8'h77, 1, 0, 0};
      tbl[12] = '{1, 0, 32'h0,        8'h88, 1, 1, 1};
      tbl[13] = '{1, 0, 32'h0,        8'h88, 0, 0, 1};
      tbl[14] = '{1, 1, 32'hDDCCBBAA, 8'hAA, 1, 0, 0};
      tbl[15] = '{0, 0, 32'h0,        8'hAA, 1, 0, 0};
      tbl[16] = '{0, 0, 32'h0,        8'hAA, 1, 0, 0};
      tbl[17] = '{1, 0, 32'h0,        8'hBB, 1, 0, 0};
      tbl[18] = '{1, 0, 32'h0,        8'hCC, 1, 0, 0};
      tbl[19] = '{1, 0, 32'h0,        8'hDD, 1, 1, 1};
      tbl[20] = '{0, 0, 32'h0,        8'hDD, 1, 1, 1};
      tbl[21] = '{1, 0, 32'h0,        8'hDD, 0, 0, 1};
      tbl[22] = '{0, 1, 32'h12345678, 8'hDD, 0, 0, 1};
      tbl[23] = '{0, 0, 32'h0,        8'hDD, 0, 0, 1};

      // Reset values on all three instances
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("rst_data",  64'(q_v[i]),    64'h0);
         chk("rst_valid", 64'(val_v[i]),  64'h0);
         chk("rst_last",  64'(last_v[i]), 64'h0);
         chk("rst_ready", 64'(rdy_v[i]),  64'h1);
         chk("rst_ovr",   64'(ovr_v[i]),  64'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Table: single frame, back to back, enable gating
      for (int i = 0; i < 24; i++) begin
         step(tbl[i].ena, tbl[i].load, tbl[i].data);
         chk($sformatf("tbl%0d_data", i),  64'(q_v[0]),    64'(tbl[i].e_data));
         chk($sformatf("tbl%0d_valid", i), 64'(val_v[0]),  64'(tbl[i].e_valid));
         chk($sformatf("tbl%0d_last", i),  64'(last_v[0]), 64'(tbl[i].e_last));
         chk($sformatf("tbl%0d_ready", i), 64'(rdy_v[0]),  64'(tbl[i].e_ready));
         chk($sformatf("tbl%0d_ovr", i),   64'(ovr_v[0]),  64'h0);
      end

      // Overrun: a load requested at r_cnt=1 is ignored
      step(1, 1, 32'h04030201);
      chk("ovr_w0", 64'(q_v[0]), 64'h01);
      step(1, 0, 32'h0);
      chk("ovr_w1", 64'(q_v[0]), 64'h02);
      chk("ovr_notready", 64'(rdy_v[0]), 64'h0);
      step(1, 1, 32'hF0F0F0F0);
      chk("ovr_w2", 64'(q_v[0]), 64'h03);
      chk("ovr_flag", 64'(ovr_v[0]), 64'(OVR_EN));
      step(1, 0, 32'h0);
      chk("ovr_w3", 64'(q_v[0]), 64'h04);
      chk("ovr_w3_last", 64'(last_v[0]), 64'h1);
      step(1, 0, 32'h0);
      chk("ovr_end_valid", 64'(val_v[0]), 64'h0);
      chk("ovr_sticky", 64'(ovr_v[0]), 64'(OVR_EN));

      // Asynchronous reset mid-frame
      step(1, 1, 32'hA1B2C3D4);
      step(1, 0, 32'h0);
      chk("mid_w1", 64'(q_v[0]), 64'hC3);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_data",  64'(q_v[0]),    64'h0);
      chk("arst_valid", 64'(val_v[0]),  64'h0);
      chk("arst_last",  64'(last_v[0]), 64'h0);
      chk("arst_ready", 64'(rdy_v[0]),  64'h1);
      chk("arst_ovr",   64'(ovr_v[0]),  64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      ena_v[0] = 1'b0; load_v[0] = 1'b0;
      @(negedge clk);

      // Random sweeps of 100 frames each
      run_random(0, 4, 100);
      run_random(1, 2, 100);
      run_random(2, 7, 100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
